scanner_bank: RTL and testbench

Parametrised bank of NUM_SCAN buffered scanner channels, the multi-channel successor to the two-scanner pair. Channels relay scanning duty round-robin, share a single transfer path granted by a round-robin arbiter, and flush an untransferred buffer when the next channel needs to take over. The block sits between the board-level key/switch inputs and the per-channel 7-segment decode. All state advances on an external `tick` enable, and there is no internal clock divider.

---
 rtl/scanner_bank_if.sv | 27 ++
 rtl/scanner_bank.sv | 171 +++++++++++++++++
 tb/tb_scanner_bank.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/scanner_bank_if.sv
// scanner_bank_if: tick/request inputs and per-channel status of the bank.
// Master drives the step enable and request pulses, slave reports state.
interface scanner_bank_if #(
  parameter int NUM_SCAN = 3,
  parameter int DEPTH    = 10,
  parameter int PW       = $clog2(DEPTH + 1),
  parameter int CW       = $clog2(NUM_SCAN)
);
  logic                     tick;
  logic                     power_on;
  logic                     start_transfer;
  logic [3*NUM_SCAN-1:0]    state;
  logic [PW*NUM_SCAN-1:0]   prog;
  logic [NUM_SCAN-1:0]      ready;
  logic                     xfer_busy;
  logic [CW-1:0]            xfer_chan;

  modport master (
    output tick, power_on, start_transfer,
    input  state, prog, ready, xfer_busy, xfer_chan
  );

  modport slave (
    input  tick, power_on, start_transfer,
    output state, prog, ready, xfer_busy, xfer_chan
  );
endinterface

// File: rtl/scanner_bank.sv
// scanner_bank: round-robin relay of buffered scanner channels sharing
// one transfer path; a full channel hands scanning duty to the next one.
module scanner_bank #(
  parameter int NUM_SCAN  = 3,
  parameter int DEPTH     = 10,
  parameter int AUTO_XFER = 0,
  parameter int PW        = $clog2(DEPTH + 1),
  parameter int CW        = $clog2(NUM_SCAN)
) (
  input  logic           clk,
  input  logic           reset,
  scanner_bank_if.slave  bus
);
  typedef enum logic [2:0] {
    LOWP = 3'd0, STBY = 3'd1, SCAN = 3'd2,
    IDLE = 3'd3, XFER = 3'd4, FLSH = 3'd5
  } st_e;

  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [PW-1:0] HALF = PW'(DEPTH / 2);
  localparam logic [PW-1:0] ONE  = PW'(1);

  st_e           st_q   [NUM_SCAN];
  st_e           st_d   [NUM_SCAN];
  logic [PW-1:0] prog_q [NUM_SCAN];
  logic [PW-1:0] prog_d [NUM_SCAN];
  logic [NUM_SCAN-1:0] pscan_q, pscan_d;
  logic          pon_q, pon_d;
  logic          pxf_q, pxf_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [CW-1:0] chan_q, chan_d;

  logic [NUM_SCAN-1:0] take, half, grant;
  logic          all_low, any_xfer;

  // Relay events and grant are all evaluated on pre-edge state.
  always_comb begin
    int idx;
    logic found;
    logic [PW-1:0] inc;
    all_low  = 1'b1;
    any_xfer = 1'b0;
    take     = '0;
    half     = '0;
    grant    = '0;
    found    = 1'b0;
    rr_d     = rr_q;
    chan_d   = chan_q;
    for (int i = 0; i < NUM_SCAN; i++) begin
      if (st_q[i] != LOWP) all_low = 1'b0;
      if (st_q[i] == XFER) any_xfer = 1'b1;
    end
    for (int i = 0; i < NUM_SCAN; i++) begin
      inc = prog_q[i] + ONE;
      if (bus.tick && st_q[i] == SCAN) begin
        if (inc == FULL) take[(i + 1) % NUM_SCAN] = 1'b1;
        if (inc == HALF) half[(i + 1) % NUM_SCAN] = 1'b1;
      end
    end
    for (int k = 1; k <= NUM_SCAN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SCAN) idx = idx - NUM_SCAN;
      if (bus.tick && (pxf_q || AUTO_XFER != 0) && !any_xfer &&
          !found && st_q[idx] == IDLE) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        rr_d       = CW'(idx);
        chan_d     = CW'(idx);
      end
    end
    pon_d = all_low && (bus.power_on || (pon_q && !bus.tick));
    pxf_d = bus.start_transfer || (pxf_q && !bus.tick);
  end

  always_comb begin
    for (int i = 0; i < NUM_SCAN; i++) begin
      st_d[i]    = st_q[i];
      prog_d[i]  = prog_q[i];
      pscan_d[i] = pscan_q[i];
      if (bus.tick) begin
        case (st_q[i])
          LOWP: begin
            if (take[i] || (i == 0 && pon_q)) begin
              st_d[i]   = SCAN;
              prog_d[i] = '0;
            end else if (half[i]) begin
              st_d[i] = STBY;
            end
          end
          STBY: begin
            if (take[i]) begin
              st_d[i]   = SCAN;
              prog_d[i] = '0;
            end
          end
          SCAN: begin
            prog_d[i] = prog_q[i] + ONE;
            if (prog_q[i] + ONE == FULL) st_d[i] = IDLE;
          end
          IDLE: begin
            if (grant[i]) st_d[i] = XFER;
            else if (take[i]) st_d[i] = FLSH;
            if (take[i]) pscan_d[i] = 1'b1;
          end
          XFER, FLSH: begin
            prog_d[i] = prog_q[i] - ONE;
            if (prog_q[i] == ONE) begin
              st_d[i]    = (pscan_q[i] || take[i]) ? SCAN : LOWP;
              pscan_d[i] = 1'b0;
            end else if (take[i]) begin
              pscan_d[i] = 1'b1;
            end
          end
          default: begin
            st_d[i]    = LOWP;
            prog_d[i]  = '0;
            pscan_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SCAN; i++) begin
        st_q[i]   <= LOWP;
        prog_q[i] <= '0;
      end
      pscan_q <= '0;
      pon_q   <= 1'b0;
      pxf_q   <= 1'b0;
      rr_q    <= CW'(NUM_SCAN - 1);
      chan_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_SCAN; i++) begin
        st_q[i]   <= st_d[i];
        prog_q[i] <= prog_d[i];
      end
      pscan_q <= pscan_d;
      pon_q   <= pon_d;
      pxf_q   <= pxf_d;
      rr_q    <= rr_d;
      chan_q  <= chan_d;
    end
  end

  logic [3*NUM_SCAN-1:0]  state_w;
  logic [PW*NUM_SCAN-1:0] prog_w;
  logic [NUM_SCAN-1:0]    rdy_w;
  logic                   busy_w;

  always_comb begin
    state_w = '0;
    prog_w  = '0;
    rdy_w   = '0;
    busy_w  = 1'b0;
    for (int i = 0; i < NUM_SCAN; i++) begin
      state_w[3*i +: 3]  = st_q[i];
      prog_w[PW*i +: PW] = prog_q[i];
      rdy_w[i]           = (st_q[i] == IDLE);
      if (st_q[i] == XFER) busy_w = 1'b1;
    end
  end

  assign bus.state     = state_w;
  assign bus.prog      = prog_w;
  assign bus.ready     = rdy_w;
  assign bus.xfer_busy = busy_w;
  assign bus.xfer_chan = chan_q;
endmodule

// File: tb/tb_scanner_bank.sv
// tb_scanner_bank: directed vector table plus hand sequences for
// flush, grant/flush collision, tick gating and async reset.
module tb_scanner_bank;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  scanner_bank_if #(.NUM_SCAN(3), .DEPTH(10)) bus ();

  scanner_bank #(
    .NUM_SCAN(3), .DEPTH(10), .AUTO_XFER(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int          n;
    logic        pon;
    logic        xfr;
    logic [8:0]  st;
    logic [11:0] pg;
    logic [2:0]  rdy;
    logic        busy;
    logic [1:0]  ch;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input logic [8:0] s,
                     input logic [11:0] p, input logic [2:0] r,
                     input logic b, input logic [1:0] c);
    tests++;
    if (bus.state !== s) begin
      fails++;
      $display("FAIL %s state got %h want %h", nm, bus.state, s);
    end
    tests++;
    if (bus.prog !== p) begin
      fails++;
      $display("FAIL %s prog got %h want %h", nm, bus.prog, p);
    end
    tests++;
    if (bus.ready !== r) begin
      fails++;
      $display("FAIL %s ready got %b want %b", nm, bus.ready, r);
    end
    tests++;
    if (bus.xfer_busy !== b) begin
      fails++;
      $display("FAIL %s busy got %b want %b", nm, bus.xfer_busy, b);
    end
    tests++;
    if (bus.xfer_chan !== c) begin
      fails++;
      $display("FAIL %s chan got %0d want %0d", nm, bus.xfer_chan, c);
    end
  endtask

  task automatic cyc(input logic p, input logic x);
    bus.power_on       = p;
    bus.start_transfer = x;
    @(negedge clk);
    bus.power_on       = 1'b0;
    bus.start_transfer = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    tv[0]  = '{1, 1'b1, 1'b0, 9'h000, 12'h000, 3'b000, 1'b0, 2'd0};
    tv[1]  = '{1, 1'b0, 1'b0, 9'h002, 12'h000, 3'b000, 1'b0, 2'd0};
    tv[2]  = '{5, 1'b0, 1'b0, 9'h00A, 12'h005, 3'b000, 1'b0, 2'd0};
    tv[3]  = '{5, 1'b0, 1'b0, 9'h013, 12'h00A, 3'b001, 1'b0, 2'd0};
    tv[4]  = '{1, 1'b0, 1'b1, 9'h013, 12'h01A, 3'b001, 1'b0, 2'd0};
    tv[5]  = '{1, 1'b0, 1'b0, 9'h014, 12'h02A, 3'b000, 1'b1, 2'd0};
    tv[6]  = '{8, 1'b0, 1'b0, 9'h09C, 12'h0A2, 3'b010, 1'b1, 2'd0};
    tv[7]  = '{2, 1'b0, 1'b0, 9'h098, 12'h2A0, 3'b010, 1'b0, 2'd0};
    tv[8]  = '{3, 1'b0, 1'b0, 9'h099, 12'h5A0, 3'b010, 1'b0, 2'd0};
    tv[9]  = '{5, 1'b0, 1'b0, 9'h0DA, 12'hAA0, 3'b110, 1'b0, 2'd0};
    tv[10] = '{2, 1'b0, 1'b1, 9'h0E2, 12'hAA2, 3'b100, 1'b1, 2'd1};
    tv[11] = '{2, 1'b0, 1'b1, 9'h0E2, 12'hA84, 3'b100, 1'b1, 2'd1};
    tv[12] = '{8, 1'b0, 1'b0, 9'h0D3, 12'hA0A, 3'b101, 1'b0, 2'd1};
    tv[13] = '{2, 1'b0, 1'b1, 9'h113, 12'hA2A, 3'b001, 1'b1, 2'd2};

    reset              = 1'b0;
    bus.tick           = 1'b1;
    bus.power_on       = 1'b0;
    bus.start_transfer = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 9'h000, 12'h000, 3'b000, 1'b0, 2'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(tv[i].pon, tv[i].xfr);
      run(tv[i].n - 1);
      chk($sformatf("v%0d", i), tv[i].st, tv[i].pg,
          tv[i].rdy, tv[i].busy, tv[i].ch);
    end

    // Flush of an untransferred buffer, then grant/flush collision.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    run(31);
    chk("flush_in", 9'h0DD, 12'hAAA, 3'b110, 1'b0, 2'd0);
    run(9);
    chk("flush_mid", 9'h0DD, 12'hAA1, 3'b110, 1'b0, 2'd0);
    run(1);
    chk("flush_out", 9'h0DA, 12'hAA0, 3'b110, 1'b0, 2'd0);
    run(8);
    cyc(1'b0, 1'b1);
    run(1);
    chk("collide", 9'h0E3, 12'hAAA, 3'b101, 1'b1, 2'd1);
    run(10);
    chk("coll_done", 9'h0D3, 12'hA0A, 3'b101, 1'b0, 2'd1);

    // Request pulsed while tick is low is held for the next tick edge.
    bus.tick = 1'b0;
    cyc(1'b0, 1'b1);
    run(2);
    chk("frozen", 9'h0D3, 12'hA0A, 3'b101, 1'b0, 2'd1);
    bus.tick = 1'b1;
    run(1);
    chk("held_grant", 9'h113, 12'hA1A, 3'b001, 1'b1, 2'd2);
    run(4);
    chk("pre_rst", 9'h113, 12'h65A, 3'b001, 1'b1, 2'd2);

    // Asynchronous reset mid-transfer, checked before any clock edge.
    #2 reset = 1'b0;
    #1 chk("async_rst", 9'h000, 12'h000, 3'b000, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    run(1);
    chk("restart", 9'h002, 12'h000, 3'b000, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
